// File: rtl/rv_pc_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pc_unit_if : fetch/redirect bundle between the PC unit and pipeline   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rv_pc_unit_if;
    logic        stall;
    logic        imem_gnt;
    logic        brq;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        taken;
    logic        trap;
    logic [31:0] mepc;
    logic [31:0] instret;

    modport slave (
        input  stall, imem_gnt, brq, is_branch, is_jal, is_jalr, imm, rs1, trap_ack,
        output pc, pc_plus4, imem_req, taken, trap, mepc, instret
    );

    modport master (
        output stall, imem_gnt, brq, is_branch, is_jal, is_jalr, imm, rs1, trap_ack,
        input  pc, pc_plus4, imem_req, taken, trap, mepc, instret
    );
endinterface
`default_nettype wire

// File: rtl/rv_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pc_unit : program counter, next-PC select and retire counter          |
// | Optional misaligned-target trap: define RV_PC_MISALIGN_TRAP_EN. Rev 1.0  |
// +--------------------------------------------------------------------------+
module rv_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic         clk,
    input  logic         rst_n,
    rv_pc_unit_if.slave  bus
);

`ifdef RV_PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, TRAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instret_q;
    logic        imem_req_q;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_sum;
    logic [31:0] redir_tgt;
    logic [31:0] pc_d;
    logic        redir;
    logic        advance;

    assign pc_plus4 = pc_q + 32'd4;
    assign jalr_sum = bus.rs1 + bus.imm;

    // Priority jalr > jal > taken branch; jal and branch share the pc+imm adder.
    always_comb begin
        redir     = 1'b1;
        redir_tgt = pc_q + bus.imm;
        if (bus.is_jalr) begin
            redir_tgt = {jalr_sum[31:1], 1'b0};
        end else if (!bus.is_jal && !(bus.is_branch && bus.brq)) begin
            redir = 1'b0;
        end
`ifndef RV_PC_MISALIGN_TRAP_EN
        redir_tgt[1:0] = 2'b00;
`endif
    end

    assign pc_d    = redir ? redir_tgt : pc_plus4;
    assign advance = (state_q == RUN) && bus.imem_gnt && !bus.stall;

`ifdef RV_PC_MISALIGN_TRAP_EN
    logic [31:0] mepc_q;
    logic        trap_q;
    logic        misaligned;

    assign misaligned = redir && (redir_tgt[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            instret_q  <= 32'd0;
            imem_req_q <= 1'b0;
`ifdef RV_PC_MISALIGN_TRAP_EN
            mepc_q     <= 32'd0;
            trap_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    imem_req_q <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
`ifdef RV_PC_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            mepc_q     <= pc_q;
                            trap_q     <= 1'b1;
                            state_q    <= TRAP;
                            imem_req_q <= 1'b0;
                        end else begin
                            pc_q      <= pc_d;
                            instret_q <= instret_q + 32'd1;
                        end
`else
                        pc_q      <= pc_d;
                        instret_q <= instret_q + 32'd1;
`endif
                    end
                end
`ifdef RV_PC_MISALIGN_TRAP_EN
                // Stall freezes the trap exit just like any other state change.
                TRAP: begin
                    if (bus.trap_ack && !bus.stall) begin
                        pc_q       <= TRAP_VECTOR;
                        trap_q     <= 1'b0;
                        state_q    <= RUN;
                        imem_req_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.imem_req = imem_req_q;
    assign bus.taken    = (state_q == RUN) && redir;
    assign bus.instret  = instret_q;
`ifdef RV_PC_MISALIGN_TRAP_EN
    assign bus.trap     = trap_q;
    assign bus.mepc     = mepc_q;
`else
    assign bus.trap     = 1'b0;
    assign bus.mepc     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv_pc_unit : directed + random stimulus against a behavioural model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rv_pc_unit;

    localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0010;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    rv_pc_unit_if bus ();

    rv_pc_unit #(
        .RESET_VECTOR (C_RESET_VECTOR),
        .TRAP_VECTOR  (C_TRAP_VECTOR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = booting, 1 = fetching, 2 = waiting for trap handler.
    int          m_mode    = 0;
    logic [31:0] m_pc      = C_RESET_VECTOR;
    logic [31:0] m_instret = 32'd0;
    logic [31:0] m_mepc    = 32'd0;
    logic        m_trap    = 1'b0;

    function automatic bit f_redirect();
        return bus.is_jalr || bus.is_jal || (bus.is_branch && bus.brq);
    endfunction

    function automatic logic [31:0] f_target();
        logic [31:0] t;
        if (bus.is_jalr) t = (bus.rs1 + bus.imm) & ~32'd1;
        else             t = m_pc + bus.imm;
`ifndef RV_PC_MISALIGN_TRAP_EN
        t = t & ~32'd3;
`endif
        return t;
    endfunction

    function automatic bit f_misaligned();
`ifdef RV_PC_MISALIGN_TRAP_EN
        return f_redirect() && (f_target() % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= 0;
            m_pc      <= C_RESET_VECTOR;
            m_instret <= 32'd0;
            m_mepc    <= 32'd0;
            m_trap    <= 1'b0;
        end else if (m_mode == 0) begin
            m_mode <= 1;
        end else if (m_mode == 1) begin
            if (bus.imem_gnt && !bus.stall) begin
                if (f_misaligned()) begin
                    m_mepc <= m_pc;
                    m_trap <= 1'b1;
                    m_mode <= 2;
                end else begin
                    m_pc      <= f_redirect() ? f_target() : m_pc + 32'd4;
                    m_instret <= m_instret + 32'd1;
                end
            end
        end else begin
            if (bus.trap_ack && !bus.stall) begin
                m_pc   <= C_TRAP_VECTOR;
                m_trap <= 1'b0;
                m_mode <= 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        #2;
        check("pc",       bus.pc,       m_pc);
        check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_mode == 1});
        check("taken",    {31'd0, bus.taken},    {31'd0, (m_mode == 1) && f_redirect()});
        check("instret",  bus.instret,  m_instret);
        check("trap",     {31'd0, bus.trap},     {31'd0, m_trap});
        check("mepc",     bus.mepc,     m_mepc);
    end

    task automatic set_in(input bit gnt, input bit stl, input bit br, input bit brq,
                          input bit jal, input bit jalr, input logic [31:0] imm,
                          input logic [31:0] rs1, input bit ack);
        @(negedge clk);
        bus.imem_gnt  = gnt;
        bus.stall     = stl;
        bus.is_branch = br;
        bus.brq       = brq;
        bus.is_jal    = jal;
        bus.is_jalr   = jalr;
        bus.imm       = imm;
        bus.rs1       = rs1;
        bus.trap_ack  = ack;
    endtask

    task automatic post(input string name, input logic [31:0] pc_exp, input logic [31:0] ir_exp);
        @(posedge clk);
        #1;
        check({name, ".pc"},      bus.pc,      pc_exp);
        check({name, ".instret"}, bus.instret, ir_exp);
    endtask

    task automatic reset_chk(input string name);
        check({name, ".pc"},       bus.pc,      C_RESET_VECTOR);
        check({name, ".imem_req"}, {31'd0, bus.imem_req}, 32'd0);
        check({name, ".trap"},     {31'd0, bus.trap},     32'd0);
        check({name, ".mepc"},     bus.mepc,    32'd0);
        check({name, ".instret"},  bus.instret, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.imem_gnt  = 1'b1;
        bus.stall     = 1'b0;
        bus.is_branch = 1'b0;
        bus.brq       = 1'b0;
        bus.is_jal    = 1'b0;
        bus.is_jalr   = 1'b0;
        bus.imm       = 32'd0;
        bus.rs1       = 32'd0;
        bus.trap_ack  = 1'b0;
        #1 rst_n = 1'b0;
        #1 reset_chk("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("boot.imem_req", {31'd0, bus.imem_req}, 32'd0);

        // Straight-line fetch after the boot cycle.
        post("boot", 32'h0, 32'd0);
        check("run.imem_req", {31'd0, bus.imem_req}, 32'd1);
        post("seq1", 32'h4, 32'd1);
        post("seq2", 32'h8, 32'd2);
        post("seq3", 32'hC, 32'd3);

        set_in(1, 0, 0, 0, 1, 0, 32'h0000_00F4, 32'd0, 0);
        post("jal_0x100", 32'h100, 32'd4);
        set_in(1, 0, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'd0, 0);
        #1 check("br_taken", {31'd0, bus.taken}, 32'd1);
        post("br_back", 32'hF0, 32'd5);
        set_in(1, 0, 0, 0, 1, 0, 32'h0000_0010, 32'd0, 0);
        post("jal_fwd", 32'h100, 32'd6);
        set_in(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'd0, 0);
        #1 check("br_not_taken", {31'd0, bus.taken}, 32'd0);
        post("br_fall", 32'h104, 32'd7);
        set_in(1, 0, 0, 0, 1, 1, 32'd0, 32'h0000_2001, 0);
        post("jalr_wins", 32'h2000, 32'd8);

        set_in(1, 1, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        post("stall1", 32'h2000, 32'd8);
        post("stall2", 32'h2000, 32'd8);
        post("stall3", 32'h2000, 32'd8);
        set_in(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        post("unstall", 32'h2004, 32'd9);
        set_in(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        post("no_gnt", 32'h2004, 32'd9);
        check("no_gnt.imem_req", {31'd0, bus.imem_req}, 32'd1);

        set_in(1, 0, 0, 0, 1, 0, 32'hFFFF_DFF8, 32'd0, 0);
        post("to_top", 32'hFFFF_FFFC, 32'd10);
        set_in(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        post("wrap", 32'h0, 32'd11);
        set_in(1, 0, 0, 0, 1, 0, 32'h0000_0040, 32'd0, 0);
        post("jal_0x40", 32'h40, 32'd12);

        set_in(1, 0, 0, 0, 1, 0, 32'h0000_0006, 32'd0, 0);
`ifdef RV_PC_MISALIGN_TRAP_EN
        post("mis_trap", 32'h40, 32'd12);
        check("mis.trap",     {31'd0, bus.trap},     32'd1);
        check("mis.mepc",     bus.mepc,              32'h40);
        check("mis.imem_req", {31'd0, bus.imem_req}, 32'd0);
        set_in(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 1);
        post("trap_ack", 32'h10, 32'd12);
        check("ack.trap", {31'd0, bus.trap}, 32'd0);
        set_in(1, 0, 0, 0, 1, 0, 32'h0000_0006, 32'd0, 0);
        post("mis_again", 32'h10, 32'd12);
        set_in(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
`else
        post("mis_forced", 32'h44, 32'd13);
        set_in(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        post("after_mis", 32'h48, 32'd14);
`endif

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_chk("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            v = $urandom;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                   ($urandom_range(0, 7) != 0) ? {{22{v[9]}}, v[9:2], 2'b00} : v,
                   $urandom, $urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                #1 reset_chk("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_pc_unit.md
RV_PC_UNIT -- requirements
Module: rv_pc_unit

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TRAP_VECTOR, 32'h0000_0010, PC value loaded on trap acknowledge.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: stall  input  1  pipeline hold; freezes PC and counter.
REQ-006 Port: imem_gnt  input  1  instruction memory accepted current fetch.
REQ-007 Port: brq  input  1  branch condition result from the branch comparator.
REQ-008 Port: is_branch / is_jal / is_jalr  input  1 each  decoded control-transfer type.
REQ-009 Port: imm  input  32  sign-extended immediate.
REQ-010 Port: rs1  input  32  register source for jalr.
REQ-011 Port: trap_ack  input  1  trap handler accepted; resume at TRAP_VECTOR.
REQ-012 Port: pc  output  32  current fetch address (registered).
REQ-013 Port: pc_plus4  output  32  pc + 4, combinational, for link writeback.
REQ-014 Port: imem_req  output  1  fetch request, registered from state.
REQ-015 Port: taken  output  1  redirect selected this cycle, combinational.
REQ-016 Port: trap / mepc  output  1 / 32  misaligned-target trap flag and faulting PC.
REQ-017 Port: instret  output  32  count of PC advances.

Function
REQ-018 Targets: br_tgt = pc + imm; jal_tgt = pc + imm; jalr_tgt = (rs1 + imm) with bit 0 cleared; all adds are modulo 2^32.
REQ-019 Next-PC priority: is_jalr > is_jal > (is_branch & brq) > pc_plus4; lower-priority selects are ignored when several are asserted.
REQ-020 taken = 1 in RUN when any of jalr, jal, or (is_branch & brq) is selected; otherwise 0.
REQ-021 FSM states: BOOT, RUN, TRAP; BOOT -> RUN unconditionally after one cycle; RUN -> TRAP on misaligned target (REQ-027); TRAP -> RUN on trap_ack.
REQ-022 imem_req = 1 only in RUN.
REQ-023 Advance condition: state RUN & imem_gnt & !stall; on advance, pc <= selected next-PC and instret <= instret + 1.
REQ-024 stall = 1 overrides imem_gnt; pc, instret, and state hold.
REQ-025 imem_gnt = 0 in RUN holds pc; the request stays asserted until granted.
REQ-026 pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; instret 32'hFFFF_FFFF wraps to 0.
REQ-027 Misaligned: the selected redirect target has bits [1:0] != 2'b00 (only when compiled in, see REQ-033).

Reset
REQ-028 On rst_n low, immediately: pc = RESET_VECTOR, state = BOOT, imem_req = 0, trap = 0, mepc = 0, instret = 0.
REQ-029 Reset asserted mid-operation (including in TRAP) aborts the operation with no partial update; the pending trap is discarded.
REQ-030 First imem_req = 1 appears in the first clock edge after rst_n deasserts + 1 cycle (BOOT dwell).

Configuration
REQ-031 Macro RV_PC_MISALIGN_TRAP_EN selects misaligned-target handling.
REQ-032 Without the macro: redirect target bits [1:0] are forced to 2'b00; the TRAP state is absent; trap = 0; mepc = 0; trap_ack is ignored.
REQ-033 With the macro, on an advance whose selected target is misaligned:
- pc holds
- mepc <= pc
- trap <= 1
- state -> TRAP
- instret is not incremented
REQ-034 With the macro, trap_ack in TRAP: pc <= TRAP_VECTOR, trap <= 0, state -> RUN; trap_ack outside TRAP is ignored.

Verification
REQ-035 Reset release, imem_gnt = 1, no control transfers -> pc sequence 0, 4, 8, 12; instret 0..3; imem_req low for the BOOT cycle.
REQ-036 pc = 0x100, is_branch = 1, brq = 1, imm = 0xFFFF_FFF0 -> taken = 1, next pc = 0xF0; with brq = 0 -> next pc = 0x104.
REQ-037 is_jalr = 1, is_jal = 1, rs1 = 0x2001, imm = 0 -> next pc = 0x2000 (jalr wins, bit 0 cleared).
REQ-038 stall = 1 for 3 cycles with imem_gnt = 1 -> pc and instret unchanged; they resume on the cycle after stall = 0.
REQ-039 Macro on: pc = 0x40, is_jal = 1, imm = 0x6 -> trap = 1, mepc = 0x40, imem_req = 0; trap_ack -> pc = 0x10. Macro off: same stimulus -> pc = 0x44.
REQ-040 rst_n pulsed low while in TRAP or mid-stream -> outputs match REQ-028 without waiting for a clock edge.
